cyclo_ram_transpose_reader: RTL and testbench

- Read-side sequencer for the P x NP sample RAM (the rams_sdp_3d block).
- Once the matrix is fully written row-major (P outer, NP inner), this block drives the RAM read port and streams the contents out column-major (NP outer, P inner) on a valid/ready interface.
- Downstream is the second-stage FFT of the cyclic-spectrum path.
- Covers the RAM's 1-cycle registered read latency and downstream backpressure without losing or duplicating samples.

---
 rtl/cyclo_ram_transpose_reader.sv | 135 +++++++++++++
 tb/tb_cyclo_ram_transpose_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cyclo_ram_transpose_reader.sv
// cyclo_ram_transpose_reader: reads a row-major P x NP sample RAM and streams it out column-major
// Ports:
//   clock, i_reset          clock and synchronous active-high reset
//   i_start                 pulse that begins one full read pass (ignored while busy or on o_done)
//   o_enable, o_out_enable  RAM enable / read enable, one read per cycle high
//   o_address_P/NP          RAM row / column address
//   i_ram_data              RAM read data, valid the cycle after the read is issued
//   o_data, o_valid, i_ready  streamed samples, valid/ready handshake
//   o_busy, o_done          pass in progress / 1-cycle pulse after the last sample is accepted
// Optional: define CYCLO_RD_BITREV_EN to drive o_address_NP with the bit-reversed column counter.
module cyclo_ram_transpose_reader #(
    parameter int P       = 32,
    parameter int NP      = 1024,
    parameter int NB_DATA = 16
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic                  o_enable,
    output logic                  o_out_enable,
    output logic [$clog2(P)-1:0]  o_address_P,
    output logic [$clog2(NP)-1:0] o_address_NP,
    input  logic [NB_DATA-1:0]    i_ram_data,
    output logic [NB_DATA-1:0]    o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int PW  = $clog2(P);
    localparam int NPW = $clog2(NP);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t               state_q;
    logic [NB_DATA-1:0]   buf_q [3];
    logic [NB_DATA-1:0]   buf_d [3];
    logic [1:0]           cnt_q, cnt_d;
    logic                 inflight_q, oe_q, en_q, valid_q, busy_q, done_q;
    logic [PW-1:0]        p_q, p_d;
    logic [NPW-1:0]       np_q, np_d;
    logic                 pop, room, last_d;

    assign pop = valid_q && i_ready;
    // Launching another read next cycle must still fit once everything committed has landed.
    assign room = (3'(cnt_q) + 3'(inflight_q) + 3'(oe_q) - 3'(pop)) < 3'd3;
    assign p_d = p_q == PW'(P - 1) ? '0 : p_q + 1'b1;
    assign np_d = p_q == PW'(P - 1) ? np_q + 1'b1 : np_q;
    assign last_d = p_d == PW'(P - 1) && np_d == NPW'(NP - 1);

    // buf_q[0] is the head and directly drives o_data; pops shift entries down.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q + 2'(inflight_q) - 2'(pop);
        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
        end
        if (inflight_q) buf_d[cnt_q - 2'(pop)] = i_ram_data;
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            buf_q      <= '{default: '0};
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            oe_q       <= 1'b0;
            en_q       <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            p_q        <= '0;
            np_q       <= '0;
        end else begin
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            valid_q    <= cnt_d != 2'd0;
            inflight_q <= oe_q;
            done_q     <= 1'b0;
            oe_q       <= 1'b0;
            en_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start && !done_q) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                        oe_q    <= 1'b1;
                        en_q    <= 1'b1;
                        p_q     <= '0;
                        np_q    <= '0;
                    end
                end
                ISSUE: begin
                    // In ISSUE the held address has always been issued already, so the next read advances it.
                    oe_q <= room;
                    en_q <= room;
                    if (room) begin
                        p_q  <= p_d;
                        np_q <= np_d;
                        if (last_d) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt_q == 2'd0 && !inflight_q && !oe_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_enable     = en_q;
    assign o_out_enable = oe_q;
    assign o_address_P  = p_q;
    assign o_data       = buf_q[0];
    assign o_valid      = valid_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

`ifdef CYCLO_RD_BITREV_EN
    if ((1 << NPW) != NP) begin : g_np_pow2
        $error("NP must be a power of two when CYCLO_RD_BITREV_EN is defined");
    end
    for (genvar i = 0; i < NPW; i++) begin : g_rev
        assign o_address_NP[i] = np_q[NPW-1-i];
    end
`else
    assign o_address_NP = np_q;
`endif

endmodule

// File: tb/tb_cyclo_ram_transpose_reader.sv
// tb_cyclo_ram_transpose_reader: self-checking bench for cyclo_ram_transpose_reader against a column-major stream model
module tb_cyclo_ram_transpose_reader;
    localparam int P = 4, NP = 8, NB = 16, N = P * NP;

    logic          clock = 1'b0;
    logic          i_reset = 1'b1, i_start = 1'b0, i_ready = 1'b1;
    logic          o_enable, o_out_enable, o_valid, o_busy, o_done;
    logic [1:0]    o_address_P;
    logic [2:0]    o_address_NP;
    logic [NB-1:0] i_ram_data = '0, o_data;
    logic [NB-1:0] mem [P][NP];
    logic [NB-1:0] got [N];
    logic [NB-1:0] prev_data;
    logic          prev_stall;
    int            checks = 0, failures = 0, acc = 0, issued = 0, done_cnt = 0;
    int            c, d0;

    always #5 clock = ~clock;

    cyclo_ram_transpose_reader #(.P(P), .NP(NP), .NB_DATA(NB)) dut (
        .clock(clock), .i_reset(i_reset), .i_start(i_start),
        .o_enable(o_enable), .o_out_enable(o_out_enable),
        .o_address_P(o_address_P), .o_address_NP(o_address_NP),
        .i_ram_data(i_ram_data), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
    );

    initial for (int p = 0; p < P; p++) for (int n = 0; n < NP; n++) mem[p][n] = NB'(p * 256 + n);

    // Registered-read RAM: data appears the cycle after the read is issued.
    always @(posedge clock) if (o_enable && o_out_enable) i_ram_data <= mem[o_address_P][o_address_NP];

    // Expected k-th sample: column-major walk, row index fastest.
    function automatic logic [NB-1:0] exp_at(input int k);
        int p, n, col;
        p = k % P;
        n = k / P;
        col = n;
`ifdef CYCLO_RD_BITREV_EN
        col = 0;
        for (int b = 0; b < 3; b++) if (n[b]) col |= 1 << (2 - b);
`endif
        return NB'(p * 256 + col);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        while (!o_done && cyc < maxc) begin
            tick();
            cyc++;
        end
        checks++;
        if (!o_done) begin
            failures++;
            $display("FAIL done_timeout actual=no_done required=done within %0d cycles", maxc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, o_enable, 0);
        chk({tag, "_oe"}, o_out_enable, 0);
        chk({tag, "_ap"}, o_address_P, 0);
        chk({tag, "_anp"}, o_address_NP, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
    endtask

    // Per-cycle checker: ordering, stall stability, occupancy bound, done accounting.
    initial begin
        prev_stall = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clock);
            if (i_reset || (i_start && !o_busy && !o_done)) begin
                acc = 0;
                issued = 0;
                prev_stall = 1'b0;
            end else begin
                chk("enable_eq", o_enable, o_out_enable);
                if (o_out_enable) begin
                    issued++;
                    chk("occupancy_le3", 32'(issued - acc <= 3), 1);
                end
                if (prev_stall) begin
                    chk("stall_valid", o_valid, 1);
                    chk("stall_data", o_data, prev_data);
                end
                if (o_valid && i_ready) begin
                    chk("sample", o_data, exp_at(acc));
                    if (acc < N) got[acc] = o_data;
                    acc++;
                end
                if (o_done) begin
                    done_cnt++;
                    chk("done_after_all", acc, N);
                end
                prev_stall = o_valid && !i_ready;
                prev_data = o_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        i_reset = 1'b0;
        chk_zero("reset");

        // Full-throughput pass with latency and literal pins.
        d0 = done_cnt;
        pulse_start();
        chk("lat_oe", o_out_enable, 1);
        chk("lat_en", o_enable, 1);
        chk("lat_ap", o_address_P, 0);
        chk("lat_anp", o_address_NP, 0);
        chk("lat_busy", o_busy, 1);
        chk("lat_valid0", o_valid, 0);
        tick();
        chk("lat_valid1", o_valid, 0);
        tick();
        chk("lat_valid2", o_valid, 1);
        chk("lat_data2", o_data, 16'h0000);
        wait_done(100, c);
        chk("pass_cycles", c + 2, N + 3);
        chk("done_busy", o_busy, 0);
        chk("pass_count", acc, N);
        chk("lit1", got[1], 16'h0100);
        chk("lit3", got[3], 16'h0300);
`ifdef CYCLO_RD_BITREV_EN
        chk("lit4", got[4], 16'h0004);
        chk("lit8", got[8], 16'h0002);
`else
        chk("lit4", got[4], 16'h0001);
        chk("lit8", got[8], 16'h0002);
`endif
        chk("lit31", got[31], 16'h0307);
        tick();
        chk("done_pulse", o_done, 0);
        chk("done_once", done_cnt - d0, 1);

        // Random backpressure.
        d0 = done_cnt;
        i_ready = 1'($urandom_range(0, 1));
        pulse_start();
        c = 0;
        while (!o_done && c < 1000) begin
            i_ready = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
        i_ready = 1'b1;
        tick();
        chk("rand_count", acc, N);
        chk("rand_done", done_cnt - d0, 1);

        // Long stall right after start.
        d0 = done_cnt;
        i_ready = 1'b0;
        pulse_start();
        repeat (19) tick();
        chk("stall_issued", issued, 3);
        chk("stall_v", o_valid, 1);
        chk("stall_d", o_data, 16'h0000);
        chk("stall_acc", acc, 0);
        i_ready = 1'b1;
        repeat (N) tick();
        chk("stall_b2b", acc, N);
        wait_done(10, c);
        tick();
        chk("stall_done", done_cnt - d0, 1);

        // Starts mid-pass and on the o_done cycle are ignored.
        d0 = done_cnt;
        pulse_start();
        repeat (10) tick();
        pulse_start();
        wait_done(100, c);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (40) tick();
        chk("ign_busy", o_busy, 0);
        chk("ign_oe", o_out_enable, 0);
        chk("ign_done", done_cnt - d0, 1);
        chk("ign_count", acc, N);

        // Reset mid-pass at sample 10.
        pulse_start();
        c = 0;
        while (acc < 10 && c < 100) begin
            tick();
            c++;
        end
        chk("rst_reach10", acc, 10);
        i_reset = 1'b1;
        tick();
        chk_zero("rst_mid");
        i_reset = 1'b0;
        d0 = done_cnt;
        repeat (40) tick();
        chk("rst_nodone", done_cnt - d0, 0);
        chk("rst_idle", o_busy, 0);

        // Reset beats a simultaneous start.
        i_reset = 1'b1;
        i_start = 1'b1;
        tick();
        i_reset = 1'b0;
        i_start = 1'b0;
        tick();
        chk("rst_prio_busy", o_busy, 0);
        chk("rst_prio_oe", o_out_enable, 0);

        // Full pass after the abort.
        pulse_start();
        wait_done(100, c);
        tick();
        chk("post_count", acc, N);
        chk("post_first", got[0], 16'h0000);
        chk("post_last", got[31], 16'h0307);
        chk("post_done", done_cnt - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
